// File: rtl/mem_stage_bytelane_pkg.sv
// Shared definitions for the byte-lane memory stage: size encodings and the
// lane mask / extract / alignment helpers, all expressed on a 64-bit maximum datapath.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] addr_lo);
    logic [7:0] m;
    case (size)
      SZ_BYTE:  m = 8'h01 << addr_lo;
      SZ_HALF:  m = 8'h03 << addr_lo;
      SZ_WORD:  m = 8'h0F << addr_lo;
      SZ_DWORD: m = 8'hFF;
      default:  m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                         input int data_w);
    logic bad;
    case (size)
      SZ_BYTE:  bad = 1'b0;
      SZ_HALF:  bad = addr_lo[0];
      SZ_WORD:  bad = (addr_lo[1:0] != 2'b00);
      SZ_DWORD: bad = (data_w != 64) || (addr_lo != 3'b000);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Shift the addressed lanes down to bit 0, then sign- or zero-extend to 64 bits.
  function automatic logic [63:0] lane_extract(input logic [63:0] word, input logic [1:0] size,
                                               input logic [2:0] addr_lo, input logic load_unsigned);
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE:  r = load_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_HALF:  r = load_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_WORD:  r = load_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      SZ_DWORD: r = sh;
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] store_replicate(input logic [63:0] data, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      SZ_BYTE:  r = {8{data[7:0]}};
      SZ_HALF:  r = {4{data[15:0]}};
      SZ_WORD:  r = {2{data[31:0]}};
      SZ_DWORD: r = data;
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_bytelane_dmem.sv
// Byte-lane data memory: combinational read, byte-enabled synchronous write.
// Contents are never reset; writes are simply blocked while reset is held.
module byte_lane_dmem
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W/8-1:0]      i_be,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Byte-enabled write port, gated by reset level at the edge.
  always_ff @(posedge clk) begin
    if (!rst && i_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_be[l]) begin
          r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage_bytelane.sv
// MIPS-style memory stage with sub-word loads/stores, lw->sw forwarding,
// misalignment flagging, stall/bubble handling and the MEM/WB register.
module mem_stage_bytelane
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  input  logic              i_stall,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [REG_AW-1:0] i_store_src,
  input  logic [REG_AW-1:0] i_dest_reg,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_size,
  input  logic              i_load_unsigned,
  output logic              o_wb_valid,
  output logic              o_wb_reg_write,
  output logic              o_wb_mem_to_reg,
  output logic              o_wb_misalign,
  output logic [REG_AW-1:0] o_wb_dest_reg,
  output logic [DATA_W-1:0] o_wb_alu_result,
  output logic [DATA_W-1:0] o_wb_load_data
);

  localparam int LANES = DATA_W / 8;
  localparam int BL    = $clog2(LANES);
  localparam int AW    = $clog2(DEPTH);

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic              r_wb_mem_to_reg;
  logic              r_wb_misalign;
  logic [REG_AW-1:0] r_wb_dest_reg;
  logic [DATA_W-1:0] r_wb_alu_result;
  logic [DATA_W-1:0] r_wb_load_data;

  logic [AW-1:0]     w_word_idx;
  logic [2:0]        w_addr_lo;
  logic              w_active;
  logic              w_mem_op;
  logic              w_misalign;
  logic              w_fwd;
  logic              w_we;
  logic [7:0]        w_mask8;
  logic [63:0]       w_store64;
  logic [63:0]       w_rep64;
  logic [63:0]       w_rdata64;
  logic [63:0]       w_ext64;
  logic [DATA_W-1:0] w_store_data;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_load_data;

  assign w_word_idx = i_alu_result[AW+BL-1:BL];
  assign w_active   = i_in_valid & ~i_stall;
  assign w_mem_op   = i_mem_read | i_mem_write;

  // Low address bits widened to the 64-bit helper domain.
  always_comb begin
    w_addr_lo         = 3'b000;
    w_addr_lo[BL-1:0] = i_alu_result[BL-1:0];
  end

  assign w_misalign = w_mem_op & is_misaligned(i_size, w_addr_lo, DATA_W);

  // Forward from the MEM/WB entry (held during a stall) into the current store.
  assign w_fwd = i_in_valid & i_mem_write & r_wb_valid & r_wb_mem_to_reg & r_wb_reg_write
               & (r_wb_dest_reg == i_store_src) & (i_store_src != {REG_AW{1'b0}});

  assign w_store_data = w_fwd ? r_wb_load_data : i_store_data;
  assign w_we         = w_active & i_mem_write & ~w_misalign;
  assign w_mask8      = byte_mask(i_size, w_addr_lo);

  // Widen store data and read data into the 64-bit helper domain.
  always_comb begin
    w_store64               = 64'd0;
    w_store64[DATA_W-1:0]   = w_store_data;
    w_rdata64               = 64'd0;
    w_rdata64[DATA_W-1:0]   = w_rdata;
  end

  assign w_rep64 = store_replicate(w_store64, i_size);
  assign w_ext64 = lane_extract(w_rdata64, i_size, w_addr_lo, i_load_unsigned);

  // Only a well-aligned read returns data; everything else loads zero.
  always_comb begin
    if (i_mem_read && !w_misalign) begin
      w_load_data = w_ext64[DATA_W-1:0];
    end else begin
      w_load_data = {DATA_W{1'b0}};
    end
  end

  byte_lane_dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dmem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_addr  (w_word_idx),
    .i_be    (w_mask8[LANES-1:0]),
    .i_wdata (w_rep64[DATA_W-1:0]),
    .o_rdata (w_rdata)
  );

  // MEM/WB register: capture on an active slot, clear on a bubble, hold on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_misalign   <= 1'b0;
      r_wb_dest_reg   <= {REG_AW{1'b0}};
      r_wb_alu_result <= {DATA_W{1'b0}};
      r_wb_load_data  <= {DATA_W{1'b0}};
    end else if (w_active) begin
      r_wb_valid      <= 1'b1;
      r_wb_reg_write  <= i_reg_write & ~w_misalign;
      r_wb_mem_to_reg <= i_mem_to_reg;
      r_wb_misalign   <= w_misalign;
      r_wb_dest_reg   <= i_dest_reg;
      r_wb_alu_result <= i_alu_result;
      r_wb_load_data  <= w_load_data;
    end else if (!i_stall) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_misalign   <= 1'b0;
      r_wb_dest_reg   <= {REG_AW{1'b0}};
      r_wb_alu_result <= {DATA_W{1'b0}};
      r_wb_load_data  <= {DATA_W{1'b0}};
    end else begin
      r_wb_valid      <= r_wb_valid;
      r_wb_reg_write  <= r_wb_reg_write;
      r_wb_mem_to_reg <= r_wb_mem_to_reg;
      r_wb_misalign   <= r_wb_misalign;
      r_wb_dest_reg   <= r_wb_dest_reg;
      r_wb_alu_result <= r_wb_alu_result;
      r_wb_load_data  <= r_wb_load_data;
    end
  end

  assign o_wb_valid      = r_wb_valid;
  assign o_wb_reg_write  = r_wb_reg_write;
  assign o_wb_mem_to_reg = r_wb_mem_to_reg;
  assign o_wb_misalign   = r_wb_misalign;
  assign o_wb_dest_reg   = r_wb_dest_reg;
  assign o_wb_alu_result = r_wb_alu_result;
  assign o_wb_load_data  = r_wb_load_data;

endmodule

// File: tb/tb_mem_stage_bytelane.sv
// Directed bench for mem_stage_bytelane (DATA_W=32, DEPTH=32) with hand-computed expectations.
module tb_mem_stage_bytelane;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  store_src;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        wb_misalign;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_load_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_bytelane #(.DATA_W(32), .DEPTH(32), .REG_AW(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_in_valid      (in_valid),
    .i_stall         (stall),
    .i_alu_result    (alu_result),
    .i_store_data    (store_data),
    .i_store_src     (store_src),
    .i_dest_reg      (dest_reg),
    .i_reg_write     (reg_write),
    .i_mem_to_reg    (mem_to_reg),
    .i_mem_read      (mem_read),
    .i_mem_write     (mem_write),
    .i_size          (size),
    .i_load_unsigned (load_unsigned),
    .o_wb_valid      (wb_valid),
    .o_wb_reg_write  (wb_reg_write),
    .o_wb_mem_to_reg (wb_mem_to_reg),
    .o_wb_misalign   (wb_misalign),
    .o_wb_dest_reg   (wb_dest_reg),
    .o_wb_alu_result (wb_alu_result),
    .o_wb_load_data  (wb_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic v, input logic st, input logic [31:0] addr, input logic [31:0] sdata,
                    input logic [4:0] src, input logic [4:0] dst, input logic rw, input logic m2r,
                    input logic mr, input logic mw, input logic [1:0] sz, input logic uns);
    in_valid = v;  stall = st;  alu_result = addr;  store_data = sdata;
    store_src = src;  dest_reg = dst;  reg_write = rw;  mem_to_reg = m2r;
    mem_read = mr;  mem_write = mw;  size = sz;  load_unsigned = uns;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st_op(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] src,
                       input logic [1:0] sz);
    op(1'b1, 1'b0, addr, data, src, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0);
    step();
  endtask

  task automatic ld_op(input logic [31:0] addr, input logic [4:0] dst, input logic [1:0] sz,
                       input logic uns);
    op(1'b1, 1'b0, addr, 32'd0, 5'd0, dst, 1'b1, 1'b1, 1'b1, 1'b0, sz, uns);
    step();
  endtask

  initial begin
    rst = 1'b0;
    op(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0);
    #1 rst = 1'b1;
    step();
    check("reset_valid", {63'd0, wb_valid}, 64'd0);
    check("reset_load", {32'd0, wb_load_data}, 64'd0);
    check("reset_dest", {59'd0, wb_dest_reg}, 64'd0);
    @(negedge clk) rst = 1'b0;

    st_op(32'h00, 32'h11223344, 5'd1, SZ_WORD);
    st_op(32'h04, 32'h55667788, 5'd1, SZ_WORD);
    st_op(32'h08, 32'hCAFEBABE, 5'd1, SZ_WORD);
    st_op(32'h0C, 32'h00000000, 5'd1, SZ_WORD);
    st_op(32'h10, 32'hA5A5A5A5, 5'd1, SZ_WORD);

    // Word round-trip
    st_op(32'h14, 32'h01010101, 5'd3, SZ_WORD);
    check("sw_valid", {63'd0, wb_valid}, 64'd1);
    check("sw_regwrite", {63'd0, wb_reg_write}, 64'd0);
    check("sw_loaddata", {32'd0, wb_load_data}, 64'd0);
    ld_op(32'h14, 5'd27, SZ_WORD, 1'b0);
    check("lw_data", {32'd0, wb_load_data}, 64'h01010101);
    check("lw_regwrite", {63'd0, wb_reg_write}, 64'd1);
    check("lw_dest", {59'd0, wb_dest_reg}, 64'd27);
    check("lw_alu", {32'd0, wb_alu_result}, 64'h14);

    // Sub-word stores and extension
    st_op(32'h03, 32'h00000080, 5'd2, SZ_BYTE);
    ld_op(32'h03, 5'd4, SZ_BYTE, 1'b0);
    check("lb_signed", {32'd0, wb_load_data}, 64'hFFFFFF80);
    ld_op(32'h03, 5'd4, SZ_BYTE, 1'b1);
    check("lbu", {32'd0, wb_load_data}, 64'h00000080);
    ld_op(32'h00, 5'd4, SZ_WORD, 1'b0);
    check("sb_word0", {32'd0, wb_load_data}, 64'h80223344);
    ld_op(32'h02, 5'd4, SZ_HALF, 1'b0);
    check("lh_signed", {32'd0, wb_load_data}, 64'hFFFF8022);
    ld_op(32'h00, 5'd4, SZ_HALF, 1'b1);
    check("lhu", {32'd0, wb_load_data}, 64'h00003344);

    // lw -> sw forwarding
    ld_op(32'h08, 5'd5, SZ_WORD, 1'b0);
    check("fwd_lw", {32'd0, wb_load_data}, 64'hCAFEBABE);
    st_op(32'h0C, 32'h00000000, 5'd5, SZ_WORD);
    ld_op(32'h0C, 5'd6, SZ_WORD, 1'b0);
    check("fwd_result", {32'd0, wb_load_data}, 64'hCAFEBABE);
    ld_op(32'h08, 5'd0, SZ_WORD, 1'b0);
    st_op(32'h0C, 32'h00000000, 5'd0, SZ_WORD);
    ld_op(32'h0C, 5'd6, SZ_WORD, 1'b0);
    check("nofwd_r0", {32'd0, wb_load_data}, 64'h00000000);
    ld_op(32'h08, 5'd6, SZ_WORD, 1'b0);
    st_op(32'h0C, 32'h12345678, 5'd7, SZ_WORD);
    ld_op(32'h0C, 5'd6, SZ_WORD, 1'b0);
    check("nofwd_mismatch", {32'd0, wb_load_data}, 64'h12345678);

    // Misalignment
    op(1'b1, 1'b0, 32'h05, 32'h0000BEEF, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0);
    step();
    check("sh_mis_flag", {63'd0, wb_misalign}, 64'd1);
    check("sh_mis_rw", {63'd0, wb_reg_write}, 64'd0);
    ld_op(32'h06, 5'd8, SZ_WORD, 1'b0);
    check("lw_mis_flag", {63'd0, wb_misalign}, 64'd1);
    check("lw_mis_rw", {63'd0, wb_reg_write}, 64'd0);
    check("lw_mis_data", {32'd0, wb_load_data}, 64'd0);
    ld_op(32'h04, 5'd8, SZ_WORD, 1'b0);
    check("mis_mem_intact", {32'd0, wb_load_data}, 64'h55667788);
    check("aligned_flag", {63'd0, wb_misalign}, 64'd0);

    // Stall then bubble
    ld_op(32'h14, 5'd9, SZ_WORD, 1'b0);
    op(1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_data", {32'd0, wb_load_data}, 64'h01010101);
      check("stall_dest", {59'd0, wb_dest_reg}, 64'd9);
      check("stall_rw", {63'd0, wb_reg_write}, 64'd1);
    end
    op(1'b0, 1'b0, 32'h14, 32'hDEADBEEF, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0);
    step();
    check("bubble_valid", {63'd0, wb_valid}, 64'd0);
    check("bubble_rw", {63'd0, wb_reg_write}, 64'd0);
    ld_op(32'h14, 5'd1, SZ_WORD, 1'b0);
    check("stall_nowrite", {32'd0, wb_load_data}, 64'h01010101);

    // Asynchronous reset with a store in flight
    ld_op(32'h10, 5'd4, SZ_WORD, 1'b0);
    check("pre_rst_data", {32'd0, wb_load_data}, 64'hA5A5A5A5);
    op(1'b1, 1'b0, 32'h10, 32'h77777777, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, wb_valid}, 64'd0);
    check("arst_data", {32'd0, wb_load_data}, 64'd0);
    check("arst_dest", {59'd0, wb_dest_reg}, 64'd0);
    check("arst_alu", {32'd0, wb_alu_result}, 64'd0);
    step();
    check("arst_hold", {63'd0, wb_valid}, 64'd0);
    @(negedge clk) rst = 1'b0;
    ld_op(32'h10, 5'd4, SZ_WORD, 1'b0);
    check("post_rst_valid", {63'd0, wb_valid}, 64'd1);
    check("post_rst_mem", {32'd0, wb_load_data}, 64'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
